tmds_channel_decoder: RTL



---
 rtl/tmds_channel_decoder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/tmds_channel_decoder.sv
// Receive side of one TMDS channel: finds word alignment by requesting bit slips
// until control tokens lock, then decodes each 10-bit word to pixel data or {C1,C0}.
module tmds_channel_decoder #(
  parameter int SEARCH_WIN    = 1024,
  parameter int CTRL_LOCK_CNT = 16,
  parameter int SLIP_SETTLE   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] tmds_in,
  output logic [7:0] data_out,
  output logic       de_out,
  output logic [1:0] c_out,
  output logic       bitslip_out,
  output logic [3:0] slip_cnt_out,
  output logic       aligned_out
);

  localparam int WIN_W = $clog2(SEARCH_WIN);
  localparam int RUN_W = $clog2(CTRL_LOCK_CNT + 1);
  localparam int SET_W = $clog2(SLIP_SETTLE + 1);

  localparam logic [WIN_W-1:0] WIN_LAST    = WIN_W'(SEARCH_WIN - 1);
  localparam logic [RUN_W-1:0] RUN_MAX     = RUN_W'(CTRL_LOCK_CNT);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SLIP_SETTLE - 1);

  typedef enum logic [1:0] {SEARCH, SLIP, SETTLE, LOCKED} state_t;

  state_t            state, next_state;
  logic              is_ctrl;
  logic [1:0]        ctrl_val;
  logic [7:0]        q;
  logic [7:0]        data_dec;
  logic [WIN_W-1:0]  win_cnt;
  logic [WIN_W-1:0]  gap_cnt;
  logic [RUN_W-1:0]  run_cnt;
  logic [SET_W-1:0]  settle_cnt;
  logic              enter_slip;
  logic              enter_lock;

  always_comb begin
    is_ctrl  = 1'b1;
    ctrl_val = 2'b00;
    case (tmds_in)
      10'b1101010100: ctrl_val = 2'b00;
      10'b0010101011: ctrl_val = 2'b01;
      10'b0101010100: ctrl_val = 2'b10;
      10'b1010101011: ctrl_val = 2'b11;
      default:        is_ctrl  = 1'b0;
    endcase
  end

  // Undo the optional inversion (bit 9), then the XOR/XNOR transition chain (bit 8).
  always_comb begin
    q           = tmds_in[9] ? ~tmds_in[7:0] : tmds_in[7:0];
    data_dec    = '0;
    data_dec[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      data_dec[i] = tmds_in[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= SEARCH;
    else     state <= next_state;
  end

  // Lock takes priority over a slip when both fall due in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      SEARCH: begin
        if (run_cnt == RUN_MAX)       next_state = LOCKED;
        else if (win_cnt == WIN_LAST) next_state = SLIP;
      end
      SLIP:   next_state = SETTLE;
      SETTLE: if (settle_cnt == SETTLE_LAST) next_state = SEARCH;
      LOCKED: if (gap_cnt == WIN_LAST)       next_state = SEARCH;
      default: next_state = SEARCH;
    endcase
  end

  always_comb begin
    enter_slip = (next_state == SLIP);
    enter_lock = (next_state == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt      <= '0;
      gap_cnt      <= '0;
      run_cnt      <= '0;
      settle_cnt   <= '0;
      data_out     <= '0;
      de_out       <= 1'b0;
      c_out        <= '0;
      bitslip_out  <= 1'b0;
      slip_cnt_out <= '0;
      aligned_out  <= 1'b0;
    end else begin
      win_cnt    <= (state == SEARCH && next_state == SEARCH) ? win_cnt + 1'b1 : '0;
      gap_cnt    <= (state == LOCKED && next_state == LOCKED && !is_ctrl) ? gap_cnt + 1'b1 : '0;
      settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;

      // Words seen while the deserializer realigns say nothing about alignment.
      if (state == SLIP || state == SETTLE || (state == LOCKED && next_state == SEARCH) || !is_ctrl)
        run_cnt <= '0;
      else if (run_cnt != RUN_MAX)
        run_cnt <= run_cnt + 1'b1;

      bitslip_out <= enter_slip;
      aligned_out <= enter_lock;
      if (enter_slip)
        slip_cnt_out <= (slip_cnt_out == 4'd9) ? 4'd0 : slip_cnt_out + 4'd1;

      if (is_ctrl) begin
        de_out <= 1'b0;
        c_out  <= ctrl_val;
      end else begin
        data_out <= data_dec;
        de_out   <= enter_lock;
      end
    end
  end

endmodule
